row_uram_arbiter: RTL and testbench

//  Per-row arbiter that shares one URAM port between the NUM_CORES RISC-V cores of a row.

---
 rtl/row_uram_arbiter.sv | 138 +++++++++++++
 tb/tb_row_uram_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_uram_arbiter.sv
// Round-robin owner of the shared per-row URAM port: one-hot grants to the cores,
// registered mux of the owner's access onto the physical port, and an "emptied" broadcast.
//
// state     | meaning
// S_IDLE    | no owner; arbitrate among requesters starting at rr_ptr
// S_GRANT   | o_owner holds the port while its req or locked is high (optional watchdog)
// S_RELEASE | one dead cycle so two owners never drive the URAM back to back
module row_uram_arbiter #(
    parameter int NUM_CORES = 8,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int HOLD_MAX  = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            i_core_req,
    input  logic [NUM_CORES-1:0]            i_core_locked,
    output logic [NUM_CORES-1:0]            o_core_grant,
    output logic                            o_uram_emptied,
    input  logic [NUM_CORES-1:0]            i_core_uram_en,
    input  logic [NUM_CORES*ADDR_W-1:0]     i_core_uram_addr,
    input  logic [NUM_CORES*DATA_W-1:0]     i_core_uram_wdata,
    input  logic [NUM_CORES-1:0]            i_core_uram_we,
    output logic                            o_URAM_en,
    output logic [ADDR_W-1:0]               o_URAM_addr,
    output logic [DATA_W-1:0]               o_URAM_wr_data,
    output logic                            o_URAM_wr_en,
    output logic [$clog2(NUM_CORES)-1:0]    o_owner
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int HC_W  = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam bit WDOG_EN = (HOLD_MAX > 0);
    localparam logic [HC_W-1:0]      HOLD_LAST = WDOG_EN ? HC_W'(HOLD_MAX - 1) : '0;
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_CORES - 1);
    localparam logic [NUM_CORES-1:0] GRANT_ONE = NUM_CORES'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic [HC_W-1:0]  hold_cnt;

    logic              own_busy;
    logic              wdog_hit;
    logic              own_gnt;
    logic              own_en;
    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    // Scan downward so the last hit written is the first requester at or after rr_ptr.
    always_comb begin : pick_blk
        int               j;
        logic [IDX_W-1:0] jj;
        pick_idx = '0;
        j        = 0;
        jj       = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_CORES) begin
                j = j - NUM_CORES;
            end
            jj = IDX_W'(j);
            if (i_core_req[jj]) begin
                pick_idx = jj;
            end
        end
    end

    assign own_busy  = i_core_req[o_owner] | i_core_locked[o_owner];
    assign wdog_hit  = WDOG_EN && (hold_cnt == HOLD_LAST);
    assign own_gnt   = o_core_grant[o_owner];
    assign own_en    = i_core_uram_en[o_owner];
    assign own_we    = i_core_uram_we[o_owner];
    assign own_addr  = i_core_uram_addr[int'(o_owner) * ADDR_W +: ADDR_W];
    assign own_wdata = i_core_uram_wdata[int'(o_owner) * DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            o_core_grant <= '0;
            rr_ptr       <= '0;
            o_owner      <= '0;
            hold_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|i_core_req) begin
                        o_core_grant <= GRANT_ONE << pick_idx;
                        o_owner      <= pick_idx;
                        hold_cnt     <= '0;
                        state        <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!own_busy || wdog_hit) begin
                        o_core_grant <= '0;
                        rr_ptr       <= (o_owner == LAST_IDX) ? '0 : o_owner + IDX_W'(1);
                        state        <= S_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    o_core_grant <= '0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

    // A write without its enable is not a URAM access, so it is dropped here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_URAM_en      <= 1'b0;
            o_URAM_addr    <= '0;
            o_URAM_wr_data <= '0;
            o_URAM_wr_en   <= 1'b0;
            o_uram_emptied <= 1'b0;
        end else begin
            o_URAM_en      <= own_gnt & own_en;
            o_URAM_addr    <= own_gnt ? own_addr : '0;
            o_URAM_wr_data <= own_gnt ? own_wdata : '0;
            o_URAM_wr_en   <= own_gnt & own_en & own_we;
            o_uram_emptied <= (state == S_IDLE) && !(|i_core_req);
        end
    end

endmodule

// File: tb/tb_row_uram_arbiter.sv
// Bench for row_uram_arbiter: directed scenarios plus random traffic, all checked every
// cycle against a transaction-level model of ownership, round-robin order and the URAM mux.
module tb_row_uram_arbiter;

    localparam int N  = 8;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int HM = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req, locked, en, we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      o_core_grant;
    logic              o_uram_emptied;
    logic              o_URAM_en, o_URAM_wr_en;
    logic [AW-1:0]     o_URAM_addr;
    logic [DW-1:0]     o_URAM_wr_data;
    logic [2:0]        o_owner;

    always #5 clk = ~clk;

    row_uram_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(HM)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_core_req        (req),
        .i_core_locked     (locked),
        .o_core_grant      (o_core_grant),
        .o_uram_emptied    (o_uram_emptied),
        .i_core_uram_en    (en),
        .i_core_uram_addr  (addr),
        .i_core_uram_wdata (wdata),
        .i_core_uram_we    (we),
        .o_URAM_en         (o_URAM_en),
        .o_URAM_addr       (o_URAM_addr),
        .o_URAM_wr_data    (o_URAM_wr_data),
        .o_URAM_wr_en      (o_URAM_wr_en),
        .o_owner           (o_owner)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: who owns the port (-1 = nobody), how many dead cycles remain before arbitration.
    int           m_owner, m_wait, m_ptr, m_last, m_hold;
    logic [N-1:0] e_grant;
    logic         e_empt, e_en, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic model_reset();
        m_owner = -1; m_wait = 0; m_ptr = 0; m_last = 0; m_hold = 0;
        e_grant = '0; e_empt = 1'b0; e_en = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
    endtask

    task automatic model_step();
        int k;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_owner >= 0) begin
            e_en   = en[m_owner];
            e_wr   = en[m_owner] & we[m_owner];
            e_addr = addr[m_owner*AW +: AW];
            e_data = wdata[m_owner*DW +: DW];
        end else begin
            e_en = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
        end
        e_empt = (m_owner < 0) && (m_wait == 0) && (req == '0);
        if (m_owner >= 0) begin
            m_hold++;
            if ((!req[m_owner] && !locked[m_owner]) || m_hold == HM) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_wait  = 1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (req != '0) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (req[k]) begin
                    m_owner = k; m_last = k; m_hold = 0;
                    break;
                end
            end
        end
        e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endtask

    task automatic check_all();
        check_val("grant",    o_core_grant, e_grant);
        check_val("onehot",   $onehot0(o_core_grant), 1);
        check_val("emptied",  o_uram_emptied, e_empt);
        check_val("uram_en",  o_URAM_en, e_en);
        check_val("uram_we",  o_URAM_wr_en, e_wr);
        check_val("uram_adr", o_URAM_addr, e_addr);
        check_val("uram_dat", o_URAM_wr_data, e_data);
        check_val("owner",    o_owner, m_last);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_val("rst_grant", o_core_grant, 0);
        check_val("rst_we",    o_URAM_wr_en, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        req = '0; locked = '0; en = '0; we = '0; addr = '0; wdata = '0;
    endtask

    int held, g1, zc, idx;
    int order[$];
    logic [N-1:0] prev_g;

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check_val("rst_grant",   o_core_grant, 0);
        check_val("rst_emptied", o_uram_emptied, 0);
        check_val("rst_owner",   o_owner, 0);
        check_val("rst_uram",    {o_URAM_en, o_URAM_wr_en, o_URAM_addr, o_URAM_wr_data}, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_val("emptied_after_rst", o_uram_emptied, 1);

        // Single request, one-cycle latency, then release and emptied.
        req = 8'h08;
        tick();
        check_val("single_grant", o_core_grant, 8'h08);
        req = '0;
        tick();
        check_val("single_drop", o_core_grant, 0);
        tick();
        tick();
        check_val("single_empt", o_uram_emptied, 1);

        // Contention from a fresh round-robin pointer.
        pulse_reset();
        req = '1; held = 0; prev_g = '0;
        for (int c = 0; c < 100 && order.size() < 9; c++) begin
            tick();
            if (o_core_grant != '0 && prev_g == '0) begin
                idx = 0;
                for (int b = 0; b < N; b++) if (o_core_grant[b]) idx = b;
                order.push_back(idx);
            end
            prev_g = o_core_grant;
            if (m_owner >= 0) begin
                held++;
                if (held == 4) req[m_owner] = 1'b0;
            end else begin
                held = 0;
                req  = '1;
            end
        end
        check_val("cont_count", order.size(), 9);
        foreach (order[i]) check_val("cont_order", order[i], i % N);
        idle_inputs();
        repeat (4) tick();

        // Locked hold keeps the grant with req low.
        req = 8'h04;
        tick();
        req = '0; locked = 8'h04;
        repeat (10) begin
            tick();
            check_val("lock_hold", o_core_grant, 8'h04);
        end
        locked = '0;
        repeat (3) tick();

        // Datapath: owner's fields reach the port, other cores ignored.
        req = 8'h20;
        tick();
        for (int r = 0; r < 4; r++) begin
            en = N'($urandom); we = N'($urandom); addr = {N{AW'($urandom)}};
            for (int c = 0; c < N; c++) wdata[c*DW +: DW] = $urandom;
            en[5] = 1'b1; we[5] = 1'b1;
            addr[5*AW +: AW]  = 12'hABC;
            wdata[5*DW +: DW] = 32'hDEADBEEF;
            tick();
            check_val("dp_addr", o_URAM_addr, 12'hABC);
            check_val("dp_data", o_URAM_wr_data, 32'hDEADBEEF);
            check_val("dp_wren", o_URAM_wr_en, 1);
        end
        en[5] = 1'b0;
        tick();
        check_val("we_no_en", o_URAM_wr_en, 0);
        idle_inputs();
        repeat (3) tick();

        // Watchdog: core 1 never lets go, core 4 waits.
        req = 8'h02; locked = 8'h02;
        tick();
        req = 8'h12;
        g1 = o_core_grant[1] ? 1 : 0; zc = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_core_grant[1]) g1++;
            else if (o_core_grant == '0) zc++;
            else break;
        end
        check_val("wdog_hold", g1, 16);
        check_val("wdog_gap",  zc, 2);
        check_val("wdog_next", o_core_grant, 8'h10);
        idle_inputs();
        repeat (4) tick();

        // Async reset with a write in flight.
        req = 8'h01;
        tick();
        en = 8'h01; we = 8'h01; addr[AW-1:0] = 12'h123; wdata[DW-1:0] = 32'h55AA55AA;
        tick();
        check_val("arst_pre_we", o_URAM_wr_en, 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_val("arst_grant", o_core_grant, 0);
        check_val("arst_we",    o_URAM_wr_en, 0);
        check_val("arst_en",    o_URAM_en, 0);
        tick();
        idle_inputs();
        #2;
        reset = 1'b1;
        tick();
        check_val("arst_empt", o_uram_emptied, 1);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < N; b++) begin
                    req[b]    = ($urandom_range(0, 3) == 0);
                    locked[b] = ($urandom_range(0, 6) == 0);
                end
            end
            en = N'($urandom); we = N'($urandom);
            for (int b = 0; b < N; b++) begin
                addr[b*AW +: AW]  = AW'($urandom);
                wdata[b*DW +: DW] = $urandom;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
